// File: rtl/memoredf_pkg.sv
// rtl/memoredf_pkg.sv - shared types and defaults for the TDMA dispatcher
package memoredf_pkg;

  localparam int DEFAULT_NUM_QUEUES  = 4;
  localparam int DEFAULT_DATA_WIDTH  = 64;
  localparam int DEFAULT_REG_SIZE    = 32;
  localparam int QUEUE_ID_WIDTH      = $clog2(DEFAULT_NUM_QUEUES);

  // One buffered request: opaque payload plus the queue it came from.
  typedef struct packed {
    logic [QUEUE_ID_WIDTH-1:0]     queue;
    logic [DEFAULT_DATA_WIDTH-1:0] payload;
  } request_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/dispatch_fifo2.sv
// rtl/dispatch_fifo2.sv - 2-entry valid/ready FIFO with registered head
// Ports: clock/reset_n; push side i_push_valid/i_push_data/o_push_ready;
//        pop side o_pop_valid/o_pop_data/i_pop_ready.
module dispatch_fifo2
  import memoredf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push_valid,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_push_ready,
  output logic             o_pop_valid,
  output logic [WIDTH-1:0] o_pop_data,
  input  logic             i_pop_ready
);

  fifo_state_t      r_state;
  fifo_state_t      w_next_state;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  // Ready depends only on state, so downstream ready never reaches upstream ready.
  assign o_push_ready = (r_state != FULL);
  assign o_pop_valid  = (r_state != EMPTY);
  assign o_pop_data   = r_head;
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = o_pop_valid && i_pop_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= EMPTY;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY:   if (w_push) w_next_state = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_next_state = FULL;
        else if (!w_push && w_pop) w_next_state = EMPTY;
      end
      FULL:    if (w_pop) w_next_state = ONE;
      default: w_next_state = EMPTY;
    endcase
  end

  // Head is always the output register; tail only holds the second entry when FULL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push && (r_state == EMPTY || (r_state == ONE && w_pop)))
        r_head <= i_push_data;
      else if (w_pop && r_state == FULL)
        r_head <= r_tail;
      if (w_push && r_state == ONE && !w_pop)
        r_tail <= i_push_data;
    end
  end

endmodule

// File: rtl/tdma_dispatcher.sv
// rtl/tdma_dispatcher.sv - forwards requests of the slot-owning queue to memory
// Ports: clock/reset_n; selection (slot owner); in_valid/in_data/in_ready per queue;
//        out_valid/out_data/out_queue/out_ready toward memory;
//        clear_counts and grant_count (per-queue saturating accept counters).
module tdma_dispatcher
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = DEFAULT_NUM_QUEUES,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int REGISTER_SIZE    = DEFAULT_REG_SIZE
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]   selection,
  input  logic [NUMBER_OF_QUEUES-1:0]           in_valid,
  input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] in_data,
  output logic [NUMBER_OF_QUEUES-1:0]           in_ready,
  output logic                                  out_valid,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]   out_queue,
  input  logic                                  out_ready,
  input  logic                                  clear_counts,
  output logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] grant_count
);

  localparam int QW = $clog2(NUMBER_OF_QUEUES);
  localparam int EW = DATA_WIDTH + QW;

  logic                     w_fifo_ready;
  logic                     w_sel_in_range;
  logic [NUMBER_OF_QUEUES-1:0] w_grant;
  logic [DATA_WIDTH-1:0]    w_payload;
  logic [EW-1:0]            w_pop_data;
  logic [REGISTER_SIZE-1:0] r_grant_count [NUMBER_OF_QUEUES];

  // Non-power-of-two queue counts leave unused selection codes that serve nobody.
  assign w_sel_in_range = ({1'b0, selection} < (QW+1)'(NUMBER_OF_QUEUES));

  // Gating with reset_n keeps every in_ready low while reset is held.
  always_comb begin
    w_payload = '0;
    in_ready  = '0;
    w_grant   = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      in_ready[i] = reset_n && w_fifo_ready && w_sel_in_range && (selection == QW'(i));
      w_grant[i]  = in_ready[i] && in_valid[i];
      if (in_ready[i]) w_payload = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  dispatch_fifo2 #(
    .WIDTH(EW)
  ) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_push_valid (|w_grant),
    .i_push_data  ({selection, w_payload}),
    .o_push_ready (w_fifo_ready),
    .o_pop_valid  (out_valid),
    .o_pop_data   (w_pop_data),
    .i_pop_ready  (out_ready)
  );

  assign out_queue = w_pop_data[EW-1 -: QW];
  assign out_data  = w_pop_data[DATA_WIDTH-1:0];

  for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_count
    // Clear wins over the old value but not over a same-cycle grant, leaving 1.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
        r_grant_count[g] <= '0;
      else if (clear_counts)
        r_grant_count[g] <= REGISTER_SIZE'(w_grant[g]);
      else if (w_grant[g] && (r_grant_count[g] != '1))
        r_grant_count[g] <= r_grant_count[g] + REGISTER_SIZE'(1);
    end
    assign grant_count[g*REGISTER_SIZE +: REGISTER_SIZE] = r_grant_count[g];
  end

endmodule

// File: tb/tb_tdma_dispatcher.sv
// tb/tb_tdma_dispatcher.sv - directed self-checking bench for tdma_dispatcher
module tb_tdma_dispatcher;

  logic         clock;
  logic         reset_n;
  logic [1:0]   selection;
  logic [3:0]   in_valid;
  logic [255:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic [1:0]   out_queue;
  logic         out_ready;
  logic         clear_counts;
  logic [127:0] grant_count;

  logic [1:0]   sel3;
  logic [2:0]   in_valid3;
  logic [47:0]  in_data3;
  logic [2:0]   in_ready3;
  logic         out_valid3;
  logic [15:0]  out_data3;
  logic [1:0]   out_queue3;
  logic         out_ready3;
  logic         clear3;
  logic [11:0]  grant_count3;

  int n_checks = 0;
  int n_errors = 0;

  tdma_dispatcher #(.NUMBER_OF_QUEUES(4), .DATA_WIDTH(64), .REGISTER_SIZE(32)) dut (
    .clock(clock), .reset_n(reset_n), .selection(selection), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_queue(out_queue), .out_ready(out_ready), .clear_counts(clear_counts),
    .grant_count(grant_count)
  );

  tdma_dispatcher #(.NUMBER_OF_QUEUES(3), .DATA_WIDTH(16), .REGISTER_SIZE(4)) dut3 (
    .clock(clock), .reset_n(reset_n), .selection(sel3), .in_valid(in_valid3),
    .in_data(in_data3), .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .out_queue(out_queue3), .out_ready(out_ready3), .clear_counts(clear3),
    .grant_count(grant_count3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_q(input int q, input logic [63:0] val);
    in_data[q*64 +: 64] = val;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; selection = 2'd0; in_valid = '0; in_data = '0;
    out_ready = 1'b0; clear_counts = 1'b0;
    sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1; clear3 = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_grant", grant_count[63:0] | grant_count[127:64], 64'd0);
    check("rst3_in_ready", 64'(in_ready3), 64'd0);
    step(); step();
    reset_n = 1'b1;

    // Streaming from queue 2
    selection = 2'd2; in_valid = 4'b0100; out_ready = 1'b1; set_q(2, 64'h10);
    #1;
    check("stream_in_ready", 64'(in_ready), 64'h4);
    step();
    check("stream_v0", 64'(out_valid), 64'd1);
    check("stream_d0", out_data, 64'h10);
    check("stream_q0", 64'(out_queue), 64'd2);
    set_q(2, 64'h11);
    step();
    check("stream_d1", out_data, 64'h11);
    set_q(2, 64'h12);
    step();
    check("stream_d2", out_data, 64'h12);
    in_valid = '0;
    step();
    check("stream_drained", 64'(out_valid), 64'd0);
    check("stream_grant2", 64'(grant_count[64 +: 32]), 64'd3);

    // Isolation and same-cycle slot change
    out_ready = 1'b0; selection = 2'd1; in_valid = 4'b1111;
    set_q(0, 64'hA0); set_q(1, 64'hB1); set_q(2, 64'hC2); set_q(3, 64'hD3);
    #1;
    check("iso_ready_q1", 64'(in_ready), 64'h2);
    step();
    selection = 2'd3;
    #1;
    check("iso_ready_q3", 64'(in_ready), 64'h8);
    step();
    check("iso_full_ready", 64'(in_ready), 64'd0);
    check("iso_head_data", out_data, 64'hB1);
    check("iso_head_queue", 64'(out_queue), 64'd1);
    in_valid = '0; out_ready = 1'b1;
    step();
    check("iso_second_data", out_data, 64'hD3);
    check("iso_second_queue", 64'(out_queue), 64'd3);
    step();
    check("iso_drained", 64'(out_valid), 64'd0);
    check("iso_grant1", 64'(grant_count[32 +: 32]), 64'd1);
    check("iso_grant3", 64'(grant_count[96 +: 32]), 64'd1);
    check("iso_grant0", 64'(grant_count[0 +: 32]), 64'd0);

    // Backpressure on queue 0
    out_ready = 1'b0; selection = 2'd0; in_valid = 4'b0001; set_q(0, 64'hA);
    step();
    set_q(0, 64'hB);
    step();
    set_q(0, 64'hC);
    #1;
    check("bp_full_ready", 64'(in_ready), 64'd0);
    step();
    check("bp_head", out_data, 64'hA);
    check("bp_grant0_2", 64'(grant_count[0 +: 32]), 64'd2);
    out_ready = 1'b1;
    step();
    check("bp_pop_b", out_data, 64'hB);
    check("bp_ready_after_pop", 64'(in_ready), 64'h1);
    step();
    check("bp_third", out_data, 64'hC);
    check("bp_grant0_3", 64'(grant_count[0 +: 32]), 64'd3);
    in_valid = '0;
    step();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Clear coincident with a grant on queue 1
    selection = 2'd1; in_valid = 4'b0010; set_q(1, 64'h55); clear_counts = 1'b1;
    step();
    clear_counts = 1'b0; in_valid = '0;
    check("clr_grant1", 64'(grant_count[32 +: 32]), 64'd1);
    check("clr_others", 64'(grant_count[0 +: 32]) | 64'(grant_count[64 +: 32]) | 64'(grant_count[96 +: 32]), 64'd0);
    step();

    // Out-of-range selection on the 3-queue instance
    sel3 = 2'd3; in_valid3 = 3'b111;
    in_data3 = {16'h3333, 16'h2222, 16'h1111};
    #1;
    check("oor_in_ready", 64'(in_ready3), 64'd0);
    step();
    check("oor_grant", 64'(grant_count3), 64'd0);
    check("oor_out_valid", 64'(out_valid3), 64'd0);

    // Saturation of a 4-bit counter on queue 0
    sel3 = 2'd0; in_valid3 = 3'b001;
    for (int k = 0; k < 14; k++) step();
    check("sat_14", 64'(grant_count3), 64'h00E);
    check("sat_data", 64'(out_data3), 64'h1111);
    for (int k = 0; k < 3; k++) step();
    check("sat_hold", 64'(grant_count3), 64'h00F);
    in_valid3 = '0;
    step();

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0; selection = 2'd2; in_valid = 4'b0100; set_q(2, 64'h77);
    step();
    set_q(2, 64'h78);
    step();
    check("mid_full", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", out_data, 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_grant", grant_count[63:0] | grant_count[127:64], 64'd0);
    check("mid_rst_grant3", 64'(grant_count3), 64'd0);
    in_valid = '0;
    step();
    reset_n = 1'b1;
    #1;
    check("post_rst_empty", 64'(out_valid), 64'd0);
    check("post_rst_ready", 64'(in_ready), 64'h4);
    in_valid = 4'b0100; set_q(2, 64'h99);
    step();
    in_valid = '0;
    check("post_rst_data", out_data, 64'h99);
    check("post_rst_grant2", 64'(grant_count[64 +: 32]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
